// File: rtl/f_mult_arbiter.sv
// Round-robin issue arbiter sharing one pipelined double-precision f_mult.
// Define F_MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.

module f_mult #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        down_valid,
  output logic [63:0] res,
  output logic        error
);

  logic [10:0]    ea, eb;
  logic [52:0]    ma, mb;
  logic [105:0]   prod, prod_n;
  logic [12:0]    e_sum;
  logic           sign;
  logic [63:0]    res_d;
  logic           err_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [63:0]    res_q [LAT];
  logic           err_q [LAT];

  always_comb begin
    ea     = a[62:52];
    eb     = b[62:52];
    sign   = a[63] ^ b[63];
    ma     = {1'b1, a[51:0]};
    mb     = {1'b1, b[51:0]};
    prod   = {53'b0, ma} * {53'b0, mb};
    prod_n = prod[105] ? prod : {prod[104:0], 1'b0};
    e_sum  = {2'b0, ea} + {2'b0, eb}
           + {12'b0, prod[105]} - 13'd1023;
    err_d  = (ea == 11'h7ff) || (eb == 11'h7ff);
    // Denormals flush to zero; mantissa is truncated
    if (err_d)
      res_d = 64'h7ff8_0000_0000_0000;
    else if (ea == '0 || eb == '0 || e_sum[12] || e_sum == '0)
      res_d = {sign, 63'b0};
    else if (e_sum >= 13'd2047)
      res_d = {sign, 11'h7ff, 52'b0};
    else
      res_d = {sign, e_sum[10:0], 52'(prod_n >> 53)};
    vld_d = {vld_q[LAT-2:0], up_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    res_q[0] <= res_d;
    err_q[0] <= err_d;
    for (int k = 1; k < LAT; k++) begin
      res_q[k] <= res_q[k-1];
      err_q[k] <= err_q[k-1];
    end
  end

  assign down_valid = vld_q[LAT-1];
  assign res        = res_q[LAT-1];
  assign error      = err_q[LAT-1];

endmodule

module f_mult_arbiter #(
  parameter  int N_REQ        = 3,
  parameter  int MAX_INFLIGHT = 4,
  localparam int FLEN         = 64,
  localparam int TAG_W        = $clog2(N_REQ),
  localparam int PW           = $clog2(MAX_INFLIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ*FLEN-1:0] req_a,
  input  logic [N_REQ*FLEN-1:0] req_b,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [FLEN-1:0]       rsp_res,
  output logic                  rsp_err,
  output logic [PW:0]           inflight,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int MUL_LAT = 4;
  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  logic [TAG_W-1:0] rr_ptr, win, cand;
  logic [TAG_W:0]   sum;
  logic             found, full, empty, issue, pop;
  logic [N_REQ-1:0] elig;
  logic [FLEN-1:0]  mul_a, mul_b, mul_res;
  logic             mul_vld, mul_err;

  logic [TAG_W-1:0] tags_q [MAX_INFLIGHT];
  logic [TAG_W-1:0] tags_d [MAX_INFLIGHT];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [FLEN-1:0]  rsp_res_q, rsp_res_d;
  logic             rsp_err_q, rsp_err_d;
  logic             proto_q, proto_d;

  assign full  = (cnt_q == (PW+1)'(MAX_INFLIGHT));
  assign empty = (cnt_q == '0);
  assign elig  = req_vld & {N_REQ{!full}};

`ifdef F_MULT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [TAG_W-1:0] rr_q, rr_d;
  assign rr_ptr = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (issue)
      rr_d = (win == TAG_W'(N_REQ-1)) ? '0 : win + TAG_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end
`endif

  // Scan starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (sum >= (TAG_W+1)'(N_REQ))
        sum = sum - (TAG_W+1)'(N_REQ);
      cand = sum[TAG_W-1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign issue   = found;
  assign req_rdy = found ? (ONE << win) : '0;
  assign mul_a   = req_a[int'(win)*FLEN +: FLEN];
  assign mul_b   = req_b[int'(win)*FLEN +: FLEN];
  assign pop     = mul_vld && !empty;

  f_mult #(.LAT(MUL_LAT)) u_mult (
    .clk        (clk),
    .rst        (~rst),
    .up_valid   (issue),
    .a          (mul_a),
    .b          (mul_b),
    .down_valid (mul_vld),
    .res        (mul_res),
    .error      (mul_err)
  );

  always_comb begin
    tags_d    = tags_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    rsp_vld_d = '0;
    rsp_res_d = rsp_res_q;
    rsp_err_d = 1'b0;
    proto_d   = proto_q | (mul_vld & empty);
    if (issue) begin
      tags_d[wp_q] = win;
      wp_d         = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d      = rp_q + PW'(1);
      rsp_vld_d = ONE << tags_q[rp_q];
      rsp_res_d = mul_res;
      rsp_err_d = (mul_err === 1'b1);
    end
    if (issue && !pop)
      cnt_d = cnt_q + (PW+1)'(1);
    else if (!issue && pop)
      cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags_q    <= '{default: '0};
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
      rsp_err_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      tags_q    <= tags_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_res_q <= rsp_res_d;
      rsp_err_q <= rsp_err_d;
      proto_q   <= proto_d;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign inflight  = cnt_q;
  assign busy      = !empty;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_f_mult_arbiter.sv
// Scoreboard bench for f_mult_arbiter: grants, ordering, backpressure,
// error routing and reset.

module tb_f_mult_arbiter;

  localparam int N    = 3;
  localparam int MAXI = 4;

  localparam logic [63:0] D1_5 = 64'h3ff8_0000_0000_0000;
  localparam logic [63:0] D2   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D3   = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D4   = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D6   = 64'h4018_0000_0000_0000;
  localparam logic [63:0] INF  = 64'h7ff0_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N*64-1:0] req_a, req_b;
  logic [N-1:0]  req_rdy, rsp_vld;
  logic [63:0]   rsp_res;
  logic          rsp_err, busy, proto_err;
  logic [2:0]    inflight;

  always #5 clk = ~clk;

  f_mult_arbiter #(.N_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rdy   (req_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err),
    .inflight  (inflight),
    .busy      (busy),
    .proto_err (proto_err)
  );

  typedef struct {
    int          tag;
    logic [63:0] res;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic exp_t model(int tag, logic [63:0] a, logic [63:0] b);
    exp_t e;
    e.tag = tag;
    e.err = (a[62:52] == 11'h7ff) || (b[62:52] == 11'h7ff);
    e.res = $realtobits($bitstoreal(a) * $bitstoreal(b));
    return e;
  endfunction

  task automatic scoreboard_mon();
    exp_t e;
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (rsp_vld !== '0) begin
          n_chk++;
          if (sb.size() == 0) begin
            $display("FAIL sb_extra: rsp_vld=%b, want no response", rsp_vld);
          end else begin
            e  = sb.pop_front();
            ev = N'(1) << e.tag;
            if (rsp_vld === ev && rsp_err === e.err &&
                (e.err || rsp_res === e.res))
              n_pass++;
            else
              $display("FAIL sb_rsp: got vld=%b res=%h err=%b, want vld=%b res=%h err=%b",
                       rsp_vld, rsp_res, rsp_err, ev, e.res, e.err);
          end
        end
        for (int i = 0; i < N; i++)
          if (req_vld[i] && req_rdy[i])
            sb.push_back(model(i, req_a[i*64 +: 64], req_b[i*64 +: 64]));
      end
    end
  endtask

  task automatic issue(input int i, input logic [63:0] a,
                       input logic [63:0] b, output bit ok);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_vld[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_rdy[i]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_vld[i] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (!busy && rsp_vld == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_vld = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (rsp_vld !== '0) $display("FAIL rst_rsp_vld: got %b want 0", rsp_vld);
    else n_pass++;
    n_chk++;
    if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", rsp_err);
    else n_pass++;
    n_chk++;
    if (rsp_res !== '0) $display("FAIL rst_rsp_res: got %h want 0", rsp_res);
    else n_pass++;
    n_chk++;
    if (proto_err !== 1'b0) $display("FAIL rst_proto: got %b want 0", proto_err);
    else n_pass++;
    n_chk++;
    if (inflight !== '0) $display("FAIL rst_inflight: got %0d want 0", inflight);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (req_rdy !== '0) $display("FAIL rst_req_rdy: got %b want 0", req_rdy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    int g[$];
    int idx;
    bit ok;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = $realtobits(1.0 + i);
      req_b[i*64 +: 64] = $realtobits(2.0 + 0.5 * i);
    end
    req_vld = '1;
    for (int c = 0; c < 60 && g.size() < 6; c++) begin
      @(negedge clk);
      if (req_rdy != '0) begin
        for (int i = 0; i < N; i++)
          if (req_rdy[i]) idx = i;
        g.push_back(idx);
      end
    end
    @(posedge clk);
    #1;
    req_vld = '0;
    n_chk++;
    if (g.size() != 6) $display("FAIL rr_count: got %0d grants want 6", g.size());
    else n_pass++;
    for (int k = 0; k < g.size(); k++) begin
      n_chk++;
      if (g[k] !== k % N)
        $display("FAIL rr_grant%0d: got %0d want %0d", k, g[k], k % N);
      else n_pass++;
    end
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL rr_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask

  task automatic test_single();
    int lat;
    bit ok;
    lat = 0;
    req_a[0 +: 64] = D2;
    req_b[0 +: 64] = D3;
    req_vld = 3'b001;
    #1;
    n_chk++;
    if (req_rdy !== 3'b001) $display("FAIL single_rdy: got %b want 001", req_rdy);
    else n_pass++;
    @(posedge clk);
    #1;
    req_vld = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_vld != '0) begin
        lat = c;
        break;
      end
    end
    n_chk++;
    if (lat != 5) $display("FAIL single_lat: got %0d want 5", lat);
    else n_pass++;
    n_chk++;
    if (rsp_vld !== 3'b001) $display("FAIL single_vld: got %b want 001", rsp_vld);
    else n_pass++;
    n_chk++;
    if (rsp_res !== D6) $display("FAIL single_res: got %h want %h", rsp_res, D6);
    else n_pass++;
    n_chk++;
    if (rsp_err !== 1'b0) $display("FAIL single_err: got %b want 0", rsp_err);
    else n_pass++;
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL single_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask

  task automatic test_backpressure();
    int issues, stalls, maxi;
    bit resume_rsp, ok;
    issues = 0;
    stalls = 0;
    maxi = 0;
    resume_rsp = 1'b0;
    req_a[0 +: 64] = D2;
    req_b[0 +: 64] = D3;
    req_a[64 +: 64] = D1_5;
    req_b[64 +: 64] = D2;
    req_vld = 3'b011;
    for (int c = 0; c < 60 && issues < 8; c++) begin
      @(negedge clk);
      if (int'(inflight) > maxi) maxi = int'(inflight);
      if (int'(inflight) == MAXI) begin
        n_chk++;
        if (req_rdy !== '0) $display("FAIL bp_full_rdy: got %b want 000", req_rdy);
        else n_pass++;
      end
      if (req_rdy != '0) begin
        issues++;
        if (issues == 5) resume_rsp = (rsp_vld != '0);
      end else if (issues == 4) begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
    req_vld = '0;
    n_chk++;
    if (issues != 8) $display("FAIL bp_issues: got %0d want 8", issues);
    else n_pass++;
    n_chk++;
    if (stalls != 1) $display("FAIL bp_stalls: got %0d want 1", stalls);
    else n_pass++;
    n_chk++;
    if (maxi != MAXI) $display("FAIL bp_max_inflight: got %0d want %0d", maxi, MAXI);
    else n_pass++;
    n_chk++;
    if (!resume_rsp) $display("FAIL bp_resume: got no pop at resume, want pop");
    else n_pass++;
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL bp_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask

  task automatic test_error_routing();
    bit ok0, ok1, ok;
    bit seen;
    issue(2, INF, D1_5, ok0);
    issue(0, D2, D3, ok1);
    n_chk++;
    if (ok0 && ok1) n_pass++;
    else $display("FAIL err_issue: got accepted=%b%b want 11", ok0, ok1);
    for (int r = 0; r < 2; r++) begin
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rsp_vld != '0) begin
          seen = 1'b1;
          break;
        end
      end
      n_chk++;
      if (!seen) begin
        $display("FAIL err_rsp%0d: got no response want one", r);
      end else if (r == 0) begin
        if (rsp_vld === 3'b100 && rsp_err === 1'b1) n_pass++;
        else $display("FAIL err_rsp0: got vld=%b err=%b want 100/1", rsp_vld, rsp_err);
      end else begin
        if (rsp_vld === 3'b001 && rsp_err === 1'b0 && rsp_res === D6) n_pass++;
        else $display("FAIL err_rsp1: got vld=%b err=%b res=%h want 001/0/%h",
                      rsp_vld, rsp_err, rsp_res, D6);
      end
    end
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL err_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask

  task automatic test_reset_midflight();
    int n;
    bit ok, seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = D2;
      req_b[i*64 +: 64] = D3;
    end
    req_vld = '1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (req_rdy != '0) n++;
    end
    @(posedge clk);
    #1;
    req_vld = '0;
    rst = 1'b0;
    sb.delete();
    #1;
    n_chk++;
    if (rsp_vld !== '0 || inflight !== '0 || busy !== 1'b0)
      $display("FAIL mid_rst: got vld=%b inflight=%0d busy=%b want 0/0/0",
               rsp_vld, inflight, busy);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(1, D2, D2, ok);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL mid_issue: got no grant want grant");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_vld != '0) begin
        seen = 1'b1;
        break;
      end
    end
    n_chk++;
    if (seen && rsp_vld === 3'b010 && rsp_res === D4) n_pass++;
    else $display("FAIL mid_rsp: got vld=%b res=%h want 010/%h", rsp_vld, rsp_res, D4);
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL mid_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask

`ifdef F_MULT_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    bit ok;
    req_a[64 +: 64] = D2;
    req_b[64 +: 64] = D2;
    req_a[128 +: 64] = D3;
    req_b[128 +: 64] = D2;
    req_vld = 3'b110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if (req_rdy !== 3'b010) $display("FAIL fp_grant%0d: got %b want 010", k, req_rdy);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    req_vld = 3'b100;
    #1;
    n_chk++;
    if (req_rdy !== 3'b100) $display("FAIL fp_req2: got %b want 100", req_rdy);
    else n_pass++;
    @(posedge clk);
    #1;
    req_vld = '0;
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL fp_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
  endtask
`endif

  initial begin
    bit ok;
    test_reset();
    fork
      scoreboard_mon();
    join_none
`ifdef F_MULT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
`endif
    test_single();
    test_backpressure();
    test_error_routing();
    test_reset_midflight();
    wait_idle(ok);
    n_chk++;
    if (ok && sb.size() == 0) n_pass++;
    else $display("FAIL final_drain: busy=%b queue=%0d want 0/0", busy, sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
